// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the mips32 IF stage.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [XLEN-1:0] MIPS_NOP     = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    // Redirect targets are word addresses; the low two bits carry no meaning.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_ifid_register.sv
// IF/ID pipeline register: sync active-low reset, load enable, flush to bubble (flush wins).
module ifid_register
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = MIPS_NOP
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  flush,
    input  ifid_t ifid_in,
    output ifid_t ifid_out
);

    ifid_t ifid_d;
    ifid_t ifid_q;

    always_comb begin
        ifid_d = ifid_q;
        if (flush) begin
            ifid_d = '{instr: NOP_INSTR, pc_plus4: {XLEN{1'b0}}, valid: 1'b0};
        end else if (load) begin
            ifid_d = ifid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ifid_q <= '{instr: NOP_INSTR, pc_plus4: {XLEN{1'b0}}, valid: 1'b0};
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid_out = ifid_q;

endmodule

// File: rtl/fetch_unit.sv
// mips32 IF stage: PC, imem request handshake, one-word skid buffer and IF/ID register.
// Stale responses after a redirect are drained and dropped.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_VECTOR,
    parameter logic [XLEN-1:0] NOP_INSTR = MIPS_NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCWrite,
    input  logic            IFID_Write,
    input  logic            BranchTaken,
    input  logic [XLEN-1:0] BranchTarget,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] IFID_Instr,
    output logic [XLEN-1:0] IFID_PCPlus4,
    output logic            IFID_Valid
);

    logic [1:0]      state_q,    state_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            req_q,      req_d;
    logic [XLEN-1:0] buf_q,      buf_d;

    logic            adv;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_inc;
    logic            ifid_load;
    logic            ifid_flush;
    ifid_t           ifid_in;
    ifid_t           ifid_out;

    always_comb begin
        adv        = PCWrite & IFID_Write;
        target     = word_align(BranchTarget);
        pc_inc     = pc_q + XLEN'(4);

        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        buf_d      = buf_q;
        ifid_load  = 1'b0;
        ifid_flush = BranchTaken;
        ifid_in    = '{instr: NOP_INSTR, pc_plus4: pc_inc, valid: 1'b0};

        case (state_q)
            ST_FETCH: begin
                if (BranchTaken) begin
                    pc_d = target;
                    if (imem_ack) begin
                        req_addr_d = target;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (imem_ack) begin
                    if (adv) begin
                        ifid_load     = 1'b1;
                        ifid_in.instr = imem_rdata;
                        ifid_in.valid = 1'b1;
                        pc_d          = pc_inc;
                        req_addr_d    = pc_inc;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = ST_HOLD;
                    end
                end else if (adv) begin
                    ifid_load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (BranchTaken) begin
                    pc_d       = target;
                    req_addr_d = target;
                    state_d    = ST_FETCH;
                end else if (adv) begin
                    ifid_load     = 1'b1;
                    ifid_in.instr = buf_q;
                    ifid_in.valid = 1'b1;
                    pc_d          = pc_inc;
                    req_addr_d    = pc_inc;
                    state_d       = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // The old request completes at its original address; the latest redirect wins.
                if (BranchTaken) begin
                    pc_d = target;
                end
                if (imem_ack) begin
                    req_addr_d = pc_d;
                    state_d    = ST_FETCH;
                end
                if (adv) begin
                    ifid_load = 1'b1;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        req_d = (state_d != ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            req_q      <= 1'b0;
            buf_q      <= {XLEN{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            req_q      <= req_d;
            buf_q      <= buf_d;
        end
    end

    // In an ack cycle the next request is presented immediately so back-to-back fetches sustain one per cycle.
    assign imem_req  = (rst_n && imem_ack) ? req_d      : req_q;
    assign imem_addr = (rst_n && imem_ack) ? req_addr_d : req_addr_q;

    ifid_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .ifid_in  (ifid_in),
        .ifid_out (ifid_out)
    );

    assign IFID_Instr   = ifid_out.instr;
    assign IFID_PCPlus4 = ifid_out.pc_plus4;
    assign IFID_Valid   = ifid_out.valid;

endmodule
